// File: rtl/instruction_decode_mw_pkg.sv
// ---------------------------------------------------------------------------
// instruction_decode_mw_pkg : shared types and helpers for the multi-lane decoder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instruction_decode_mw_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_I      = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
  } branch_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SH
  } imm_type_e;

  typedef enum logic [1:0] {
    PIPE_NONE, PIPE_ALU, PIPE_MEM, PIPE_BRU
  } exe_pipe_e;

  // MEM_X is the funct3[1:0]=3 encoding, only reachable on illegal loads/stores
  typedef enum logic [1:0] {
    MEM_B, MEM_H, MEM_W, MEM_X
  } mem_size_e;

  typedef struct packed {
    alu_op_e    alu_op;
    branch_op_e branch_op;
    imm_type_e  imm_type;
    exe_pipe_e  exe_pipe;
    logic       alu_src_imm;
    logic       a1_pc;
    logic       register_write;
    logic       mem_load;
    logic       mem_store;
    mem_size_e  mem_size;
    logic       mem_unsigned;
    logic       illegal;
  } id_ctrl_t;

  typedef struct packed {
    id_ctrl_t    ctrl;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } id_uop_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic branch_op_e br_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return BR_EQ;
      3'b001:  return BR_NE;
      3'b100:  return BR_LT;
      3'b101:  return BR_GE;
      3'b110:  return BR_LTU;
      3'b111:  return BR_GEU;
      default: return BR_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_type_e t);
    case (t)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_SH:  return {27'b0, instr[24:20]};
      default: return 32'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decode_mw_decode_lane.sv
// ---------------------------------------------------------------------------
// instruction_decode_mw_decode_lane : combinational RV32I decode of one lane
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_decode_mw_decode_lane
  import instruction_decode_mw_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output id_uop_t     uop
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       use_a1;
  logic       use_a2;
  logic       use_rd;
  id_ctrl_t   ctrl;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl   = '0;
    use_a1 = 1'b0;
    use_a2 = 1'b0;
    use_rd = 1'b0;
    case (opcode)
      OP_R: begin
        {use_a1, use_a2, use_rd} = 3'b111;
        ctrl.alu_op         = alu_from_f3(funct3, funct7[5]);
        ctrl.exe_pipe       = PIPE_ALU;
        ctrl.register_write = 1'b1;
        ctrl.illegal        = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                              ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101));
      end
      OP_I: begin
        {use_a1, use_rd}    = 2'b11;
        ctrl.imm_type       = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
        ctrl.alu_op         = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        ctrl.alu_src_imm    = 1'b1;
        ctrl.exe_pipe       = PIPE_ALU;
        ctrl.register_write = 1'b1;
      end
      OP_LOAD: begin
        {use_a1, use_rd}    = 2'b11;
        ctrl.imm_type       = IMM_I;
        ctrl.alu_src_imm    = 1'b1;
        ctrl.exe_pipe       = PIPE_MEM;
        ctrl.register_write = 1'b1;
        ctrl.mem_load       = 1'b1;
        ctrl.mem_size       = mem_size_e'(funct3[1:0]);
        ctrl.mem_unsigned   = funct3[2];
        ctrl.illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        {use_a1, use_a2}    = 2'b11;
        ctrl.imm_type       = IMM_S;
        ctrl.alu_src_imm    = 1'b1;
        ctrl.exe_pipe       = PIPE_MEM;
        ctrl.mem_store      = 1'b1;
        ctrl.mem_size       = mem_size_e'(funct3[1:0]);
        ctrl.mem_unsigned   = funct3[2];
        ctrl.illegal        = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        {use_a1, use_a2}    = 2'b11;
        ctrl.imm_type       = IMM_B;
        ctrl.alu_op         = ALU_SUB;
        ctrl.branch_op      = br_from_f3(funct3);
        ctrl.exe_pipe       = PIPE_BRU;
        ctrl.illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        use_rd              = 1'b1;
        ctrl.imm_type       = IMM_J;
        ctrl.branch_op      = BR_JUMP;
        ctrl.alu_src_imm    = 1'b1;
        ctrl.a1_pc          = 1'b1;
        ctrl.exe_pipe       = PIPE_BRU;
        ctrl.register_write = 1'b1;
      end
      OP_JALR: begin
        {use_a1, use_rd}    = 2'b11;
        ctrl.imm_type       = IMM_I;
        ctrl.branch_op      = BR_JUMP;
        ctrl.alu_src_imm    = 1'b1;
        ctrl.exe_pipe       = PIPE_BRU;
        ctrl.register_write = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        use_rd              = 1'b1;
        ctrl.imm_type       = IMM_U;
        ctrl.alu_src_imm    = 1'b1;
        ctrl.a1_pc          = (opcode == OP_AUIPC);
        ctrl.exe_pipe       = PIPE_ALU;
        ctrl.register_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // Illegal ops keep their decoded fields but must have no side effects
    ctrl.register_write = ctrl.register_write && (instr[11:7] != 5'd0) && !ctrl.illegal;
    ctrl.mem_load       = ctrl.mem_load && !ctrl.illegal;
    ctrl.mem_store      = ctrl.mem_store && !ctrl.illegal;
    if (ctrl.illegal) ctrl.exe_pipe = PIPE_NONE;

    uop         = '0;
    uop.ctrl    = ctrl;
    uop.a1      = use_a1 ? instr[19:15] : 5'd0;
    uop.a2      = use_a2 ? instr[24:20] : 5'd0;
    uop.rd      = use_rd ? instr[11:7]  : 5'd0;
    uop.imm_ext = imm_gen(instr[31:7], ctrl.imm_type);
    uop.pc      = pc;
    uop.pc_inc  = pc + 32'd4;
  end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_mw.sv
// ---------------------------------------------------------------------------
// instruction_decode_mw : DECODE_WIDTH-lane decode into a SKID_DEPTH bundle buffer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_decode_mw
  import instruction_decode_mw_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int SKID_DEPTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DECODE_WIDTH-1:0]               in_lane_valid,
  input  logic [32*DECODE_WIDTH-1:0]            in_instr,
  input  logic [32*DECODE_WIDTH-1:0]            in_pc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DECODE_WIDTH-1:0]               out_lane_valid,
  output logic [DECODE_WIDTH*$bits(id_uop_t)-1:0] out_uop,
  output logic [DECODE_WIDTH*2-1:0]             out_raw_dep
);

  localparam int UW = $bits(id_uop_t);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);

  id_uop_t                     dec_uop  [DECODE_WIDTH];
  id_uop_t                     lane_uop [DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0]     lane_en;
  logic [DECODE_WIDTH*UW-1:0]  bundle_uop;
  logic [2*DECODE_WIDTH-1:0]   bundle_dep;
  logic                        push;
  logic                        pop;

  logic [CW-1:0]               count_q, count_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [DECODE_WIDTH-1:0]     lv_q  [SKID_DEPTH];
  logic [DECODE_WIDTH-1:0]     lv_d  [SKID_DEPTH];
  logic [DECODE_WIDTH*UW-1:0]  uop_q [SKID_DEPTH];
  logic [DECODE_WIDTH*UW-1:0]  uop_d [SKID_DEPTH];
  logic [2*DECODE_WIDTH-1:0]   dep_q [SKID_DEPTH];
  logic [2*DECODE_WIDTH-1:0]   dep_d [SKID_DEPTH];

  generate
    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
      instruction_decode_mw_decode_lane u_decode_lane (
        .instr (in_instr[32*g +: 32]),
        .pc    (in_pc[32*g +: 32]),
        .uop   (dec_uop[g])
      );
    end
  endgenerate

  // A lane is live only while every lower lane is also valid
  always_comb begin
    logic run;
    run     = 1'b1;
    lane_en = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      run        = run & in_lane_valid[i];
      lane_en[i] = run;
      lane_uop[i] = run ? dec_uop[i] : id_uop_t'('0);
      bundle_uop[i*UW +: UW] = lane_uop[i];
    end
  end

  always_comb begin
    bundle_dep = '0;
    for (int i = 1; i < DECODE_WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        if (lane_en[j] && lane_uop[j].ctrl.register_write) begin
          if (lane_uop[i].a1 != 5'd0 && lane_uop[i].a1 == lane_uop[j].rd) bundle_dep[2*i]   = 1'b1;
          if (lane_uop[i].a2 != 5'd0 && lane_uop[i].a2 == lane_uop[j].rd) bundle_dep[2*i+1] = 1'b1;
        end
      end
    end
  end

  assign in_ready = (count_q != CW'(SKID_DEPTH));
  assign out_valid = (count_q != '0);
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lv_d     = lv_q;
    uop_d    = uop_q;
    dep_d    = dep_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        lv_d[wr_ptr_q]  = lane_en;
        uop_d[wr_ptr_q] = bundle_uop;
        dep_d[wr_ptr_q] = bundle_dep;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < SKID_DEPTH; k++) begin
        lv_q[k]  <= '0;
        uop_q[k] <= '0;
        dep_q[k] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lv_q     <= lv_d;
      uop_q    <= uop_d;
      dep_q    <= dep_d;
    end
  end

  assign out_lane_valid = lv_q[rd_ptr_q];
  assign out_uop        = uop_q[rd_ptr_q];
  assign out_raw_dep    = dep_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode_mw.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode_mw : directed scoreboard bench for instruction_decode_mw
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instruction_decode_mw;
  import instruction_decode_mw_pkg::*;

  localparam int DW = 2;
  localparam int UW = $bits(id_uop_t);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_lane_valid = '0;
  logic [32*DW-1:0]  in_instr = '0;
  logic [32*DW-1:0]  in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_lane_valid;
  logic [DW*UW-1:0]  out_uop;
  logic [2*DW-1:0]   out_raw_dep;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_decode_mw #(.DECODE_WIDTH(DW), .SKID_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_uop        (out_uop),
    .out_raw_dep    (out_raw_dep)
  );

  typedef struct packed {
    logic        zero;
    logic [3:0]  alu;
    logic [2:0]  imt;
    logic [1:0]  pipe;
    logic        rw, ld, st;
    logic [1:0]  sz;
    logic        us, ill;
    logic [4:0]  a1, a2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_lane_t;

  typedef struct {
    logic [1:0] lv;
    logic [3:0] dep;
    exp_lane_t  l0;
    exp_lane_t  l1;
  } exp_bundle_t;

  exp_bundle_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_lane_t L(input alu_op_e alu, input imm_type_e it, input exe_pipe_e p,
                                  input logic rw, input logic ld, input logic st,
                                  input logic [1:0] sz, input logic us, input logic ill,
                                  input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                                  input logic [31:0] imm, input logic [31:0] pc);
    exp_lane_t e;
    e = '0;
    e.alu = alu; e.imt = it; e.pipe = p;
    e.rw = rw; e.ld = ld; e.st = st; e.sz = sz; e.us = us; e.ill = ill;
    e.a1 = a1; e.a2 = a2; e.rd = rd; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  function automatic exp_lane_t Z();
    exp_lane_t e;
    e = '0;
    e.zero = 1'b1;
    return e;
  endfunction

  function automatic exp_bundle_t B(input logic [1:0] lv, input logic [3:0] dep,
                                    input exp_lane_t l0, input exp_lane_t l1);
    exp_bundle_t b;
    b.lv = lv; b.dep = dep; b.l0 = l0; b.l1 = l1;
    return b;
  endfunction

  task automatic check_lane(input int i, input exp_lane_t e, input id_uop_t u);
    string p;
    p = $sformatf("lane%0d", i);
    if (e.zero) begin
      chk({p, ".uop_nonzero"}, {31'b0, |u}, 32'd0);
    end else begin
      chk({p, ".alu_op"},   32'(u.ctrl.alu_op),         32'(e.alu));
      chk({p, ".imm_type"}, 32'(u.ctrl.imm_type),       32'(e.imt));
      chk({p, ".exe_pipe"}, 32'(u.ctrl.exe_pipe),       32'(e.pipe));
      chk({p, ".reg_wr"},   32'(u.ctrl.register_write), 32'(e.rw));
      chk({p, ".mem_load"}, 32'(u.ctrl.mem_load),       32'(e.ld));
      chk({p, ".mem_st"},   32'(u.ctrl.mem_store),      32'(e.st));
      chk({p, ".mem_size"}, 32'(u.ctrl.mem_size),       32'(e.sz));
      chk({p, ".mem_uns"},  32'(u.ctrl.mem_unsigned),   32'(e.us));
      chk({p, ".illegal"},  32'(u.ctrl.illegal),        32'(e.ill));
      chk({p, ".a1"},       32'(u.a1),                  32'(e.a1));
      chk({p, ".a2"},       32'(u.a2),                  32'(e.a2));
      chk({p, ".rd"},       32'(u.rd),                  32'(e.rd));
      chk({p, ".imm"},      u.imm_ext,                  e.imm);
      chk({p, ".pc"},       u.pc,                       e.pc);
      chk({p, ".pc_inc"},   u.pc_inc,                   e.pc + 32'd4);
    end
  endtask

  // Monitor: compares the head bundle on every cycle it is consumed
  exp_bundle_t m_e;
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb_q.delete();
    end else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_bundle", 32'd1, 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        chk("out_lane_valid", 32'(out_lane_valid), 32'(m_e.lv));
        chk("out_raw_dep",    32'(out_raw_dep),    32'(m_e.dep));
        check_lane(0, m_e.l0, id_uop_t'(out_uop[0 +: UW]));
        check_lane(1, m_e.l1, id_uop_t'(out_uop[UW +: UW]));
      end
    end
  end

  task automatic drive(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1);
    in_lane_valid = lv;
    in_instr      = {i1, i0};
    in_pc         = {p1, p0};
  endtask

  task automatic push(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1, input exp_bundle_t e);
    int cyc;
    drive(lv, i0, i1, p0, p1);
    in_valid = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (cyc == 20) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      sb_q.push_back(e);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (!out_valid && sb_q.size() == 0) break;
    end
    if (cyc == 20) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  exp_bundle_t      b_t1, b_t2;
  logic [DW*UW-1:0] snap;

  initial begin
    b_t1 = B(2'b11, 4'b1100,
             L(ALU_ADD, IMM_I,    PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h100),
             L(ALU_ADD, IMM_NONE, PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd1, 5'd1, 5'd2, 32'd0, 32'h104));
    b_t2 = B(2'b11, 4'b0000,
             L(ALU_ADD, IMM_I, PIPE_MEM, 1, 1, 0, 2'd1, 1, 0, 5'd2, 5'd0, 5'd3, 32'd0, 32'h200),
             L(ALU_ADD, IMM_S, PIPE_MEM, 0, 0, 1, 2'd2, 0, 0, 5'd2, 5'd1, 5'd0, 32'd4, 32'h204));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",      32'(out_valid),      32'd0);
    chk("rst_in_ready",       32'(in_ready),       32'd1);
    chk("rst_out_lane_valid", 32'(out_lane_valid), 32'd0);
    chk("rst_out_uop_nz",     32'(|out_uop),       32'd0);
    chk("rst_out_raw_dep",    32'(out_raw_dep),    32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU pair with RAW on both sources, then load/store sizes, then illegals
    out_ready = 1'b1;
    push(2'b11, 32'h00500093, 32'h00108133, 32'h100, 32'h104, b_t1);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    push(2'b11, 32'h00015183, 32'h00112223, 32'h200, 32'h204, b_t2);
    push(2'b11, 32'hFFFFFFFF, 32'h400010B3, 32'hFFFFFFF8, 32'hFFFFFFFC,
         B(2'b11, 4'b0000,
           L(ALU_ADD, IMM_NONE, PIPE_NONE, 0, 0, 0, 2'd0, 0, 1, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFFFFF8),
           L(ALU_SLL, IMM_NONE, PIPE_NONE, 0, 0, 0, 2'd0, 0, 1, 5'd0, 5'd0, 5'd1, 32'd0, 32'hFFFFFFFC)));
    drain();

    // Backpressure: two bundles fill the buffer, head holds, then ordered release
    out_ready = 1'b0;
    push(2'b11, 32'h008000EF, 32'h00209863, 32'h400, 32'h404,
         B(2'b11, 4'b0100,
           L(ALU_ADD, IMM_J, PIPE_BRU, 1, 0, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd1, 32'd8,  32'h400),
           L(ALU_SUB, IMM_B, PIPE_BRU, 0, 0, 0, 2'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'd16, 32'h404)));
    snap = out_uop;
    push(2'b11, 32'h123452B7, 32'h4032D313, 32'h410, 32'h414,
         B(2'b11, 4'b0100,
           L(ALU_ADD, IMM_U,  PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h410),
           L(ALU_SRA, IMM_SH, PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd5, 5'd0, 5'd6, 32'd3,        32'h414)));
    chk("t4_in_ready_full", 32'(in_ready),           32'd0);
    chk("t4_out_valid",     32'(out_valid),          32'd1);
    chk("t4_head_stable",   32'(|(out_uop ^ snap)),  32'd0);
    out_ready = 1'b1;
    push(2'b11, 32'h00001397, 32'h40038433, 32'h420, 32'h424,
         B(2'b11, 4'b0100,
           L(ALU_ADD, IMM_U,    PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd7, 32'h1000, 32'h420),
           L(ALU_SUB, IMM_NONE, PIPE_ALU, 1, 0, 0, 2'd0, 0, 0, 5'd7, 5'd0, 5'd8, 32'd0,    32'h424)));
    drain();

    // Flush while full with a pending push, then flush with a pushable bundle
    out_ready = 1'b0;
    push(2'b11, 32'h00500093, 32'h00108133, 32'h100, 32'h104, b_t1);
    push(2'b11, 32'h00015183, 32'h00112223, 32'h200, 32'h204, b_t2);
    drive(2'b11, 32'h00500093, 32'h00108133, 32'h600, 32'h604);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_flush_out_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_push_dropped", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t5_still_empty", 32'(out_valid), 32'd0);

    // Non-contiguous lane valids, then an illegal store with an ignored lane
    out_ready = 1'b1;
    push(2'b10, 32'h00500093, 32'h00108133, 32'h700, 32'h704, B(2'b00, 4'b0000, Z(), Z()));
    push(2'b01, 32'h00113023, 32'h00500093, 32'h500, 32'h504,
         B(2'b01, 4'b0000,
           L(ALU_ADD, IMM_S, PIPE_NONE, 0, 0, 0, 2'd3, 0, 1, 5'd2, 5'd1, 5'd0, 32'd0, 32'h500),
           Z()));
    drain();

    // Asynchronous reset with a bundle waiting at the head
    out_ready = 1'b0;
    push(2'b11, 32'h00500093, 32'h00108133, 32'h100, 32'h104, b_t1);
    chk("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid",      32'(out_valid),      32'd0);
    chk("t6_rst_out_lane_valid", 32'(out_lane_valid), 32'd0);
    chk("t6_rst_out_uop_nz",     32'(|out_uop),       32'd0);
    chk("t6_rst_out_raw_dep",    32'(out_raw_dep),    32'd0);
    chk("t6_rst_in_ready",       32'(in_ready),       32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    push(2'b11, 32'h00015183, 32'h00112223, 32'h200, 32'h204, b_t2);
    drain();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
